ws2812_tx_reader: RTL and testbench
===================================

Name: ws2812_tx_reader

Overview:
- Read side of the WS2812 pixel RAM.
- The host writes GRB pixels into the dual-port RAM. This block reads them back one per LED over the RAM's registered read port (1-cycle latency).
- Each pixel is serialised MSB-first onto the WS2812 single-wire data line with NRZ pulse-width timing.
- Each frame ends with a low latch/reset period.

Parameters:
- LED_NUM, 16, number of LEDs per frame (>=1).
- DATA_WIDTH, 24, bits per pixel, {G[7:0],R[7:0],B[7:0]}.
- ADDR_WIDTH, $clog2(LED_NUM)+1, RAM read-address width.
- T0H_CYC, 20, high time of a '0' bit in clk cycles (400 ns @ 50 MHz).
- T1H_CYC, 40, high time of a '1' bit (800 ns).
- BIT_CYC, 63, total bit period (1.26 us). Must satisfy T0H_CYC < T1H_CYC < BIT_CYC.
- RST_CYC, 15000, latch low time after the last bit (300 us).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle request to send one frame.
- rd_addr  out  ADDR_WIDTH  read address to the RAM.
- rd_data  in  DATA_WIDTH  RAM q; valid 1 cycle after rd_addr is sampled.
- dout  out  1  WS2812 serial data line.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset (async, active-high): state=IDLE, dout=0, busy=0, done=0, rd_addr=0, all counters and shift register cleared. Reset mid-frame aborts immediately with no partial-bit glitch beyond the reset edge.
- States: IDLE, PRIME, SEND, LATCH.
- IDLE:
  - dout=0, rd_addr=0.
  - start=1 -> PRIME; busy=1 from the next cycle.
  - start while busy is ignored.
- PRIME (2 cycles):
  - Cycle 1: rd_addr=0 sampled by the RAM.
  - Cycle 2: shift register <= rd_data; pixel index=0; bit counter=DATA_WIDTH-1 -> SEND.
- SEND:
  - Each bit lasts exactly BIT_CYC cycles, driven by cycle counter c = 0..BIT_CYC-1.
  - dout=1 while c < (bit ? T1H_CYC : T0H_CYC), else dout=0. The bit sent is shift register MSB.
  - At c=BIT_CYC-1: shift left by 1, decrement the bit counter.
  - rd_addr = pixel index+1 throughout SEND (prefetch), so rd_data is stable long before it is needed.
  - At c=BIT_CYC-1 of the last bit (bit counter 0):
    - If pixel index < LED_NUM-1: shift register <= rd_data, index+1, bit counter reloaded. No gap cycles between pixels.
    - Else -> LATCH.
- LATCH:
  - dout=0 for exactly RST_CYC cycles.
  - On the final cycle -> IDLE, with done=1 for one cycle in the IDLE entry cycle and busy=0 in the same cycle.
- dout is registered: its first rising edge appears on the cycle after the PRIME capture cycle.
- Frame length from start to done: 2 + LED_NUM*DATA_WIDTH*BIT_CYC + RST_CYC cycles (+1 for the start register).
- RAM contents may be rewritten during SEND; each pixel uses whatever value was read at its load point (no tearing protection).
- rd_addr never exceeds LED_NUM-1. During the last pixel the prefetch address is held at LED_NUM-1, not LED_NUM.

Optional Feature:
- Macro WS2812_AUTO_REFRESH_EN.
- Defined: start is treated as a level "run" input. At the end of LATCH, if start=1 the FSM goes directly to PRIME; busy stays high and done still pulses once per frame. If start=0 it goes to IDLE.
- Undefined: start is edge/pulse-accepted only in IDLE; exactly one frame per accepted start.

Test Plan (bench parameters LED_NUM=2, T0H_CYC=2, T1H_CYC=4, BIT_CYC=6, RST_CYC=10; behavioural RAM model with 1-cycle read latency):
- RAM[0]=24'hA50000, RAM[1]=24'h000001, start pulse -> dout bit 0 of pixel 0 high 4 cycles / low 2 cycles; next bit high 2 / low 4; last pixel's final bit high 4; 48 bits total, no gaps.
- Same frame -> done pulses exactly 2+2*24*6+10 = 300 cycles after the PRIME entry; busy falls on the same cycle; dout=0 through LATCH.
- Monitor rd_addr -> 0 during PRIME, 1 during SEND of both pixels, never 2.
- start re-pulsed mid-SEND -> ignored; exactly one done pulse; waveform identical to the first scenario.
- Assert rst during bit 10 of pixel 0 while dout=1 -> dout=0, busy=0, rd_addr=0 asynchronously. A following start produces a clean full frame.
- WS2812_AUTO_REFRESH_EN defined, start held high for 2 frames then low -> two back-to-back frames with no IDLE cycle between; done pulses twice; FSM returns to IDLE after the second LATCH.

Source files
------------

// File: rtl/ws2812_tx_reader.sv
// WS2812 frame reader: fetches GRB pixels from a registered-read RAM and serialises them as NRZ pulses.
// Optional WS2812_AUTO_REFRESH_EN: start acts as a level "run" input that chains frames back to back.
module ws2812_tx_reader #(
    parameter int LED_NUM    = 16,
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = $clog2(LED_NUM) + 1,
    parameter int T0H_CYC    = 20,
    parameter int T1H_CYC    = 40,
    parameter int BIT_CYC    = 63,
    parameter int RST_CYC    = 15000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  dout,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = $clog2(BIT_CYC + 1);
    localparam int LW = $clog2(RST_CYC + 1);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam int AW = ADDR_WIDTH;

    localparam logic [AW-1:0] LAST_IDX       = AW'(LED_NUM - 1);
    localparam logic [AW-1:0] FIRST_PREFETCH = (LED_NUM > 1) ? AW'(1) : AW'(0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        SEND  = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t                state_r;
    logic                  prime_cnt_r;
    logic [CW-1:0]         c_r;
    logic [BW-1:0]         bit_cnt_r;
    logic [AW-1:0]         idx_r;
    logic [LW-1:0]         lat_cnt_r;
    logic [DATA_WIDTH-1:0] sr_r;
    logic [AW-1:0]         rd_addr_r;
    logic                  dout_r;
    logic                  busy_r;
    logic                  done_r;

    logic [AW:0]           addr_sum_s;
    logic [AW-1:0]         next_addr_s;
    logic                  c_last_s;
    logic                  bit_last_s;
    logic                  pix_last_s;

    // Line level for a given bit value at cycle offset c within its bit period.
    function automatic logic high_at(input logic b, input logic [CW-1:0] c);
        high_at = b ? (c < CW'(T1H_CYC)) : (c < CW'(T0H_CYC));
    endfunction

    // Prefetch address for the pixel after next, clamped to the last LED.
    always_comb begin
        addr_sum_s  = (AW+1)'(idx_r) + (AW+1)'(2);
        next_addr_s = LAST_IDX;
        if (addr_sum_s > (AW+1)'(LED_NUM - 1)) begin
            next_addr_s = LAST_IDX;
        end else begin
            next_addr_s = addr_sum_s[AW-1:0];
        end
        c_last_s   = (c_r == CW'(BIT_CYC - 1));
        bit_last_s = (bit_cnt_r == BW'(0));
        pix_last_s = (idx_r == LAST_IDX);
    end

    // Frame sequencer; dout is computed from the next-cycle counters so it stays aligned with c_r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            prime_cnt_r <= 1'b0;
            c_r         <= '0;
            bit_cnt_r   <= '0;
            idx_r       <= '0;
            lat_cnt_r   <= '0;
            sr_r        <= '0;
            rd_addr_r   <= '0;
            dout_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    dout_r    <= 1'b0;
                    rd_addr_r <= '0;
                    if (start) begin
                        state_r     <= PRIME;
                        prime_cnt_r <= 1'b0;
                        busy_r      <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                PRIME: begin
                    dout_r <= 1'b0;
                    if (!prime_cnt_r) begin
                        prime_cnt_r <= 1'b1;
                    end else begin
                        sr_r      <= rd_data;
                        idx_r     <= '0;
                        bit_cnt_r <= BW'(DATA_WIDTH - 1);
                        c_r       <= '0;
                        rd_addr_r <= FIRST_PREFETCH;
                        dout_r    <= high_at(rd_data[DATA_WIDTH-1], CW'(0));
                        state_r   <= SEND;
                    end
                end
                SEND: begin
                    if (!c_last_s) begin
                        c_r    <= c_r + CW'(1);
                        dout_r <= high_at(sr_r[DATA_WIDTH-1], c_r + CW'(1));
                    end else if (!bit_last_s) begin
                        c_r       <= '0;
                        sr_r      <= {sr_r[DATA_WIDTH-2:0], 1'b0};
                        bit_cnt_r <= bit_cnt_r - BW'(1);
                        dout_r    <= high_at(sr_r[DATA_WIDTH-2], CW'(0));
                    end else if (!pix_last_s) begin
                        c_r       <= '0;
                        sr_r      <= rd_data;
                        idx_r     <= idx_r + AW'(1);
                        bit_cnt_r <= BW'(DATA_WIDTH - 1);
                        rd_addr_r <= next_addr_s;
                        dout_r    <= high_at(rd_data[DATA_WIDTH-1], CW'(0));
                    end else begin
                        c_r       <= '0;
                        lat_cnt_r <= '0;
                        rd_addr_r <= '0;
                        dout_r    <= 1'b0;
                        state_r   <= LATCH;
                    end
                end
                LATCH: begin
                    dout_r <= 1'b0;
                    if (lat_cnt_r == LW'(RST_CYC - 1)) begin
                        lat_cnt_r <= '0;
                        done_r    <= 1'b1;
`ifdef WS2812_AUTO_REFRESH_EN
                        if (start) begin
                            state_r     <= PRIME;
                            prime_cnt_r <= 1'b0;
                            busy_r      <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
`else
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
`endif
                    end else begin
                        lat_cnt_r <= lat_cnt_r + LW'(1);
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    dout_r    <= 1'b0;
                    busy_r    <= 1'b0;
                    rd_addr_r <= '0;
                end
            endcase
        end
    end

    assign rd_addr = rd_addr_r;
    assign dout    = dout_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_ws2812_tx_reader.sv
// Directed bench for ws2812_tx_reader with a 1-cycle-latency RAM model and a cycle-exact waveform model.
module tb_ws2812_tx_reader;

    localparam int LED_NUM = 2;
    localparam int DW      = 24;
    localparam int AW      = $clog2(LED_NUM) + 1;
    localparam int T0H     = 2;
    localparam int T1H     = 4;
    localparam int BITC    = 6;
    localparam int RSTC    = 10;
    localparam int SEND_END  = 2 + LED_NUM * DW * BITC;   // first LATCH cycle index
    localparam int FRAME_LEN = SEND_END + RSTC;           // done index relative to PRIME entry

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          dout;
    logic          busy;
    logic          done;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] exp_pix [0:LED_NUM-1];

    int tests;
    int fails;

    ws2812_tx_reader #(
        .LED_NUM(LED_NUM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .T0H_CYC(T0H), .T1H_CYC(T1H), .BIT_CYC(BITC), .RST_CYC(RSTC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .rd_addr(rd_addr),
        .rd_data(rd_data), .dout(dout), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) rd_data <= ram[rd_addr];

    // k counts negedges after the edge that enters PRIME (k=0 is the first PRIME cycle).
    function automatic logic exp_dout(input int k);
        int j;
        int b;
        int c;
        logic [DW-1:0] v;
        logic bv;
        if (k < 2 || k >= SEND_END) return 1'b0;
        j  = k - 2;
        b  = j / BITC;
        c  = j % BITC;
        v  = exp_pix[b / DW];
        bv = v[DW - 1 - (b % DW)];
        return (c < (bv ? T1H : T0H)) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic [AW-1:0] exp_addr(input int k);
        logic [AW-1:0] one;
        one = 1;
        return (k >= 2 && k < SEND_END) ? one : '0;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (dout !== 1'b0) begin fails++; $display("FAIL reset_dout got %b exp 0", dout); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
        tests++; if (rd_addr !== '0) begin fails++; $display("FAIL reset_addr got %0d exp 0", rd_addr); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Full single frame; optional extra start pulse at restart_k must be ignored.
    task automatic test_frame(input string tag, input int restart_k);
        int done_cnt;
        logic exp_busy;
        logic exp_done;
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < FRAME_LEN + 6; k++) begin
            @(negedge clk);
            start = (k == restart_k) ? 1'b1 : 1'b0;
            exp_busy = (k < FRAME_LEN) ? 1'b1 : 1'b0;
            exp_done = (k == FRAME_LEN) ? 1'b1 : 1'b0;
            tests++;
            if (dout !== exp_dout(k)) begin
                fails++; $display("FAIL %s_dout k=%0d got %b exp %b", tag, k, dout, exp_dout(k));
            end
            tests++;
            if (busy !== exp_busy) begin
                fails++; $display("FAIL %s_busy k=%0d got %b exp %b", tag, k, busy, exp_busy);
            end
            tests++;
            if (done !== exp_done) begin
                fails++; $display("FAIL %s_done k=%0d got %b exp %b", tag, k, done, exp_done);
            end
            tests++;
            if (rd_addr !== exp_addr(k)) begin
                fails++; $display("FAIL %s_addr k=%0d got %0d exp %0d", tag, k, rd_addr, exp_addr(k));
            end
            if (done === 1'b1) done_cnt++;
        end
        tests++;
        if (done_cnt !== 1) begin
            fails++; $display("FAIL %s_done_count got %0d exp 1", tag, done_cnt);
        end
    endtask

    // Reset asserted in the first high cycle of bit 10 of pixel 0 (a '0' bit).
    task automatic test_reset_mid_frame();
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k <= 2 + 10 * BITC; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        tests++; if (dout !== 1'b1) begin fails++; $display("FAIL midrst_pre_dout got %b exp 1", dout); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL midrst_pre_busy got %b exp 1", busy); end
        #1 rst = 1'b1;
        #1;
        tests++; if (dout !== 1'b0) begin fails++; $display("FAIL midrst_dout got %b exp 0", dout); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b exp 0", busy); end
        tests++; if (rd_addr !== '0) begin fails++; $display("FAIL midrst_addr got %0d exp 0", rd_addr); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (dout !== 1'b0) begin fails++; $display("FAIL midrst_idle_dout got %b exp 0", dout); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_idle_busy got %b exp 0", busy); end
    endtask

`ifdef WS2812_AUTO_REFRESH_EN
    task automatic test_auto_refresh();
        int done_cnt;
        int kk;
        logic e_dout;
        logic e_busy;
        logic e_done;
        logic [AW-1:0] e_addr;
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 2 * FRAME_LEN + 6; k++) begin
            @(negedge clk);
            start = (k < FRAME_LEN + 100) ? 1'b1 : 1'b0;
            kk = (k < FRAME_LEN) ? k : k - FRAME_LEN;
            e_dout = (k < 2 * FRAME_LEN) ? exp_dout(kk) : 1'b0;
            e_addr = (k < 2 * FRAME_LEN) ? exp_addr(kk) : '0;
            e_busy = (k < 2 * FRAME_LEN) ? 1'b1 : 1'b0;
            e_done = (k == FRAME_LEN || k == 2 * FRAME_LEN) ? 1'b1 : 1'b0;
            tests++;
            if (dout !== e_dout) begin fails++; $display("FAIL auto_dout k=%0d got %b exp %b", k, dout, e_dout); end
            tests++;
            if (busy !== e_busy) begin fails++; $display("FAIL auto_busy k=%0d got %b exp %b", k, busy, e_busy); end
            tests++;
            if (done !== e_done) begin fails++; $display("FAIL auto_done k=%0d got %b exp %b", k, done, e_done); end
            tests++;
            if (rd_addr !== e_addr) begin fails++; $display("FAIL auto_addr k=%0d got %0d exp %0d", k, rd_addr, e_addr); end
            if (done === 1'b1) done_cnt++;
        end
        tests++;
        if (done_cnt !== 2) begin fails++; $display("FAIL auto_done_count got %0d exp 2", done_cnt); end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < (1 << AW); i++) ram[i] = 24'hFFFFFF;
        ram[0] = 24'hA50000;
        ram[1] = 24'h000001;
        exp_pix[0] = 24'hA50000;
        exp_pix[1] = 24'h000001;

        test_reset();
`ifdef WS2812_AUTO_REFRESH_EN
        test_auto_refresh();
`else
        test_frame("frame", -1);
        test_frame("restart", 50);
        test_reset_mid_frame();
        test_frame("after_rst", -1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
